diagnosis_snapshot_receiver: RTL and testbench

DIAGNOSIS_SNAPSHOT_RECEIVER -- requirements
Module: diagnosis_snapshot_receiver

---
 rtl/diagnosis_snapshot_receiver_pkg.sv | 21 ++
 rtl/diagnosis_snapshot_receiver.sv | 173 +++++++++++++++++
 tb/tb_diagnosis_snapshot_receiver.sv | 480 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/diagnosis_snapshot_receiver_pkg.sv
// Shared debug-NoC flit definitions for the diagnosis snapshot receiver.
package diagnosis_snapshot_receiver_pkg;

  localparam int FLIT_W    = 18;
  localparam int CONTENT_W = 16;

  localparam logic [3:0]  CLASS_SNAPSHOT_DEF = 4'h7;
  localparam logic [15:0] DROP_COUNT_MAX     = 16'hFFFF;

  typedef enum logic [1:0] {
    FLIT_PAYLOAD = 2'b00,
    FLIT_HEAD    = 2'b01,
    FLIT_LAST    = 2'b10,
    FLIT_SINGLE  = 2'b11
  } flit_type_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] val);
    return (val == DROP_COUNT_MAX) ? val : val + 16'd1;
  endfunction

endpackage

// File: rtl/diagnosis_snapshot_receiver.sv
// Parses diagnosis snapshot packets from the debug NoC into a header record
// followed by 32-bit data words; drops other classes and flags malformed packets.
module diagnosis_snapshot_receiver
  import diagnosis_snapshot_receiver_pkg::*;
#(
  parameter logic [3:0] CLASS_SNAPSHOT = CLASS_SNAPSHOT_DEF,
  parameter int         EV_ID_WIDTH    = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [FLIT_W-1:0]      dbgnoc_in_flit_i,
  input  logic                   dbgnoc_in_valid_i,
  output logic                   dbgnoc_in_ready_o,
  output logic                   hdr_valid_o,
  input  logic                   hdr_ready_i,
  output logic [15:0]            hdr_core_id_o,
  output logic [EV_ID_WIDTH-1:0] hdr_ev_id_o,
  output logic [31:0]            hdr_time_o,
  output logic                   hdr_last_o,
  output logic                   word_valid_o,
  input  logic                   word_ready_i,
  output logic [31:0]            word_data_o,
  output logic                   word_last_o,
  output logic                   err_o,
  output logic [15:0]            drop_count_o
);

  // state    | meaning
  // IDLE     | waiting for a packet start
  // SRC      | expecting core_id flit
  // EVID     | expecting event id flit
  // TS_HI    | expecting timestamp high half
  // TS_LO    | expecting timestamp low half (LAST ends a header-only packet)
  // HDR_OUT  | presenting header, input stalled
  // DATA_HI  | expecting data word high half
  // DATA_LO  | expecting data word low half (LAST marks final word)
  // WORD_OUT | presenting data word, input stalled
  // DROP     | discarding a foreign packet until its LAST flit
  typedef enum logic [3:0] {
    S_IDLE, S_SRC, S_EVID, S_TS_HI, S_TS_LO,
    S_HDR_OUT, S_DATA_HI, S_DATA_LO, S_WORD_OUT, S_DROP
  } state_e;

  state_e                 state_q, state_d;
  logic [15:0]            core_id_q, core_id_d;
  logic [EV_ID_WIDTH-1:0] ev_id_q, ev_id_d;
  logic [31:0]            time_q, time_d;
  logic                   hdr_last_q, hdr_last_d;
  logic [31:0]            word_q, word_d;
  logic                   word_last_q, word_last_d;
  logic                   err_q, err_d;
  logic [15:0]            drop_count_q, drop_count_d;

  flit_type_e           ftype;
  logic [CONTENT_W-1:0] content;
  logic                 accept;
  logic                 drop_inc;

  assign ftype   = flit_type_e'(dbgnoc_in_flit_i[17:16]);
  assign content = dbgnoc_in_flit_i[CONTENT_W-1:0];

  // Input is held off while a result waits for its consumer and during reset.
  assign dbgnoc_in_ready_o = rst_ni && (state_q != S_HDR_OUT) && (state_q != S_WORD_OUT);
  assign accept            = dbgnoc_in_valid_i && dbgnoc_in_ready_o;

  always_comb begin
    state_d      = state_q;
    core_id_d    = core_id_q;
    ev_id_d      = ev_id_q;
    time_d       = time_q;
    hdr_last_d   = hdr_last_q;
    word_d       = word_q;
    word_last_d  = word_last_q;
    err_d        = 1'b0;
    drop_inc     = 1'b0;
    case (state_q)
      S_HDR_OUT: if (hdr_ready_i) state_d = hdr_last_q ? S_IDLE : S_DATA_HI;
      S_WORD_OUT: if (word_ready_i) state_d = word_last_q ? S_IDLE : S_DATA_HI;
      default: begin
        if (accept) begin
          if (ftype == FLIT_HEAD && state_q != S_DROP) begin
            err_d = (state_q != S_IDLE);
            if (content[10:7] == CLASS_SNAPSHOT) begin
              state_d = S_SRC;
            end else begin
              state_d  = S_DROP;
              drop_inc = 1'b1;
            end
          end else begin
            case (state_q)
              S_IDLE: begin
                if (ftype == FLIT_SINGLE) drop_inc = 1'b1;
                else                      err_d    = 1'b1;
              end
              S_SRC, S_EVID, S_TS_HI, S_DATA_HI: begin
                if (ftype == FLIT_PAYLOAD) begin
                  case (state_q)
                    S_SRC:   begin core_id_d = content; state_d = S_EVID; end
                    S_EVID:  begin ev_id_d = content[EV_ID_WIDTH-1:0]; state_d = S_TS_HI; end
                    S_TS_HI: begin time_d[31:16] = content; state_d = S_TS_LO; end
                    default: begin word_d[31:16] = content; state_d = S_DATA_LO; end
                  endcase
                end else begin
                  err_d   = 1'b1;
                  state_d = S_IDLE;
                end
              end
              S_TS_LO: begin
                if (ftype == FLIT_SINGLE) begin
                  err_d   = 1'b1;
                  state_d = S_IDLE;
                end else begin
                  time_d[15:0] = content;
                  hdr_last_d   = (ftype == FLIT_LAST);
                  state_d      = S_HDR_OUT;
                end
              end
              S_DATA_LO: begin
                if (ftype == FLIT_SINGLE) begin
                  err_d   = 1'b1;
                  state_d = S_IDLE;
                end else begin
                  word_d[15:0] = content;
                  word_last_d  = (ftype == FLIT_LAST);
                  state_d      = S_WORD_OUT;
                end
              end
              S_DROP: if (ftype == FLIT_LAST) state_d = S_IDLE;
              default: state_d = S_IDLE;
            endcase
          end
        end
      end
    endcase
    drop_count_d = drop_inc ? sat_inc16(drop_count_q) : drop_count_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      core_id_q    <= '0;
      ev_id_q      <= '0;
      time_q       <= '0;
      hdr_last_q   <= 1'b0;
      word_q       <= '0;
      word_last_q  <= 1'b0;
      err_q        <= 1'b0;
      drop_count_q <= '0;
    end else begin
      state_q      <= state_d;
      core_id_q    <= core_id_d;
      ev_id_q      <= ev_id_d;
      time_q       <= time_d;
      hdr_last_q   <= hdr_last_d;
      word_q       <= word_d;
      word_last_q  <= word_last_d;
      err_q        <= err_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign hdr_valid_o   = (state_q == S_HDR_OUT);
  assign hdr_core_id_o = core_id_q;
  assign hdr_ev_id_o   = ev_id_q;
  assign hdr_time_o    = time_q;
  assign hdr_last_o    = hdr_last_q;
  assign word_valid_o  = (state_q == S_WORD_OUT);
  assign word_data_o   = word_q;
  assign word_last_o   = word_last_q;
  assign err_o         = err_q;
  assign drop_count_o  = drop_count_q;

endmodule

// File: tb/tb_diagnosis_snapshot_receiver.sv
// Self-checking bench for diagnosis_snapshot_receiver: directed and random packet
// streams compared against a flit-stream reference model.
module tb_diagnosis_snapshot_receiver;

  localparam int EVW = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [17:0] flit = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        hdr_valid, hdr_ready = 1'b0;
  logic [15:0] hdr_core;
  logic [EVW-1:0] hdr_ev;
  logic [31:0] hdr_time;
  logic        hdr_last;
  logic        word_valid, word_ready = 1'b0;
  logic [31:0] word_data;
  logic        word_last;
  logic        err;
  logic [15:0] drop_count;

  always #5 clk = ~clk;

  diagnosis_snapshot_receiver #(.CLASS_SNAPSHOT(4'h7), .EV_ID_WIDTH(EVW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .dbgnoc_in_flit_i(flit), .dbgnoc_in_valid_i(in_valid), .dbgnoc_in_ready_o(in_ready),
    .hdr_valid_o(hdr_valid), .hdr_ready_i(hdr_ready), .hdr_core_id_o(hdr_core),
    .hdr_ev_id_o(hdr_ev), .hdr_time_o(hdr_time), .hdr_last_o(hdr_last),
    .word_valid_o(word_valid), .word_ready_i(word_ready), .word_data_o(word_data),
    .word_last_o(word_last), .err_o(err), .drop_count_o(drop_count)
  );

  // Record: header = {0, core16, ev16, time32, last}; word = {1, 32'0, data32, last}
  typedef logic [65:0] rec_t;
  rec_t        exp_q[$];
  rec_t        obs_q[$];
  logic [17:0] tx_q[$];
  int tests_run = 0, failed = 0;
  int exp_err = 0, obs_err = 0, err0 = 0, n_acc = 0;
  bit rdy_rand = 1'b0;

  // Reference model state: 0 idle, 1 in snapshot packet, 2 dropping
  int          m_mode = 0, m_pos = 0, m_drops = 0;
  logic [15:0] m_core, m_ev;
  logic [31:0] m_time, m_word;

  function automatic void model_reset();
    m_mode = 0; m_pos = 0; m_drops = 0;
  endfunction

  function automatic void model_flit(input logic [17:0] f);
    logic [1:0]  t;
    logic [15:0] c;
    t = f[17:16];
    c = f[15:0];
    if (m_mode == 2) begin
      if (t == 2'b10) m_mode = 0;
    end else if (t == 2'b01) begin
      if (m_mode == 1) exp_err++;
      if (c[10:7] == 4'h7) begin
        m_mode = 1; m_pos = 0;
      end else begin
        m_mode = 2;
        if (m_drops < 65535) m_drops++;
      end
    end else if (m_mode == 0) begin
      if (t == 2'b11) begin
        if (m_drops < 65535) m_drops++;
      end else exp_err++;
    end else if (m_pos < 3) begin
      if (t == 2'b00) begin
        if (m_pos == 0) m_core = c;
        else if (m_pos == 1) m_ev = {8'h00, c[7:0]};
        else m_time[31:16] = c;
        m_pos++;
      end else begin
        exp_err++; m_mode = 0;
      end
    end else if (m_pos == 3) begin
      if (t == 2'b11) begin
        exp_err++; m_mode = 0;
      end else begin
        m_time[15:0] = c;
        exp_q.push_back({1'b0, m_core, m_ev, m_time, t == 2'b10});
        if (t == 2'b10) m_mode = 0; else m_pos = 4;
      end
    end else if (((m_pos - 4) % 2) == 0) begin
      if (t == 2'b00) begin
        m_word[31:16] = c; m_pos++;
      end else begin
        exp_err++; m_mode = 0;
      end
    end else begin
      if (t == 2'b11) begin
        exp_err++; m_mode = 0;
      end else begin
        m_word[15:0] = c;
        exp_q.push_back({1'b1, 32'd0, m_word, t == 2'b10});
        if (t == 2'b10) m_mode = 0; else m_pos++;
      end
    end
  endfunction

  function automatic void push_flit(input logic [1:0] t, input logic [15:0] c);
    tx_q.push_back({t, c});
    model_flit({t, c});
  endfunction

  function automatic void push_head(input logic [3:0] cls);
    logic [15:0] c;
    c = 16'($urandom);
    c[10:7] = cls;
    push_flit(2'b01, c);
  endfunction

  function automatic void gen_snapshot(input int nwords);
    push_head(4'h7);
    for (int i = 0; i < 3; i++) push_flit(2'b00, 16'($urandom));
    if (nwords == 0) begin
      push_flit(2'b10, 16'($urandom));
    end else begin
      for (int i = 0; i < 2 * nwords; i++) push_flit(2'b00, 16'($urandom));
      push_flit(2'b10, 16'($urandom));
    end
  endfunction

  // Reworked: snapshot with nwords words = HEAD, core, ev, ts_hi, ts_lo, 2*nwords flits, last is LAST
  function automatic void gen_snapshot_ok(input int nwords);
    if (nwords == 0) begin
      gen_snapshot(0);
    end else begin
      push_head(4'h7);
      for (int i = 0; i < 4 + 2 * nwords - 1; i++) push_flit(2'b00, 16'($urandom));
      push_flit(2'b10, 16'($urandom));
    end
  endfunction

  function automatic void gen_foreign(input int npay);
    logic [3:0] cls;
    cls = 4'($urandom_range(0, 15));
    if (cls == 4'h7) cls = 4'h2;
    push_head(cls);
    for (int i = 0; i < npay; i++) push_flit(2'b00, 16'($urandom));
    push_flit(2'b10, 16'($urandom));
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (hdr_valid && hdr_ready) obs_q.push_back({1'b0, hdr_core, 8'h00, hdr_ev, hdr_time, hdr_last});
      if (word_valid && word_ready) obs_q.push_back({1'b1, 32'd0, word_data, word_last});
      if (err) obs_err++;
      if (in_valid && in_ready) n_acc++;
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rdy_rand) begin
        hdr_ready  = ($urandom_range(0, 3) != 0);
        word_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic send_flit(input logic [17:0] f, output bit ok);
    flit = f; in_valid = 1'b1; ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic send_all(output bit ok);
    bit ok1;
    ok = 1'b1;
    while (tx_q.size() > 0) begin
      if ($urandom_range(0, 4) == 0) begin @(posedge clk); #1; end
      send_flit(tx_q.pop_front(), ok1);
      if (!ok1) ok = 1'b0;
    end
  endtask

  task automatic drain(input int n, output bit ok);
    for (int i = 0; i < 2000; i++) begin
      if (obs_q.size() >= n && !hdr_valid && !word_valid) break;
      @(posedge clk); #1;
    end
    ok = (obs_q.size() >= n);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic start_test();
    exp_q.delete(); obs_q.delete(); tx_q.delete();
    exp_err = 0; err0 = obs_err;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests_run++;
    if ({hdr_valid, word_valid, err, hdr_last, word_last, in_ready} !== 6'b0) begin
      failed++; $display("FAIL reset_ctrl: got %b required 000000", {hdr_valid, word_valid, err, hdr_last, word_last, in_ready});
    end
    tests_run++;
    if (drop_count !== 16'h0) begin
      failed++; $display("FAIL reset_drop: got %h required 0000", drop_count);
    end
    tests_run++;
    if ({hdr_core, hdr_ev, hdr_time, word_data} !== '0) begin
      failed++; $display("FAIL reset_data: got core=%h ev=%h time=%h data=%h required all 0", hdr_core, hdr_ev, hdr_time, word_data);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    bit ok, ok2;
    start_test();
    push_flit(2'b01, 16'h0380); push_flit(2'b00, 16'h0003); push_flit(2'b00, 16'h0012);
    push_flit(2'b00, 16'hAAAA); push_flit(2'b00, 16'hBBBB); push_flit(2'b00, 16'h1234);
    push_flit(2'b10, 16'h5678);
    send_all(ok); drain(2, ok2);
    tests_run++;
    if (!ok || !ok2 || obs_q.size() != 2) begin
      failed++; $display("FAIL basic_count: got %0d records (send ok=%0d) required 2", obs_q.size(), ok);
    end else begin
      tests_run++;
      if (obs_q[0] !== {1'b0, 16'h0003, 16'h0012, 32'hAAAABBBB, 1'b0}) begin
        failed++; $display("FAIL basic_hdr: got %h required %h", obs_q[0], {1'b0, 16'h0003, 16'h0012, 32'hAAAABBBB, 1'b0});
      end
      tests_run++;
      if (obs_q[1] !== {1'b1, 32'd0, 32'h12345678, 1'b1}) begin
        failed++; $display("FAIL basic_word: got %h required %h", obs_q[1], {1'b1, 32'd0, 32'h12345678, 1'b1});
      end
    end
    tests_run++;
    if (obs_err - err0 != 0) begin
      failed++; $display("FAIL basic_err: got %0d pulses required 0", obs_err - err0);
    end
  endtask

  task automatic test_hdr_only();
    bit ok, ok2;
    start_test();
    gen_snapshot_ok(0);
    gen_snapshot_ok(1);
    send_all(ok); drain(exp_q.size(), ok2);
    tests_run++;
    if (!ok || !ok2 || obs_q.size() != exp_q.size()) begin
      failed++; $display("FAIL hdronly_count: got %0d records required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      tests_run++;
      if (obs_q[i] !== exp_q[i]) begin
        failed++; $display("FAIL hdronly_rec%0d: got %h required %h", i, obs_q[i], exp_q[i]);
      end
    end
    tests_run++;
    if (obs_q.size() > 0 && obs_q[0][0] !== 1'b1) begin
      failed++; $display("FAIL hdronly_last: got hdr_last=%b required 1", obs_q[0][0]);
    end
  endtask

  task automatic test_hdr_stall();
    bit ok, ok2;
    int acc0;
    start_test();
    rdy_rand = 1'b0; hdr_ready = 1'b0; word_ready = 1'b0;
    push_flit(2'b01, 16'h0380); push_flit(2'b00, 16'h00A5); push_flit(2'b00, 16'h0042);
    push_flit(2'b00, 16'h1111); push_flit(2'b00, 16'h2222); push_flit(2'b00, 16'hDEAD);
    push_flit(2'b10, 16'hBEEF);
    for (int i = 0; i < 5; i++) send_flit(tx_q.pop_front(), ok);
    flit = tx_q[0]; in_valid = 1'b1; acc0 = n_acc;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests_run++;
      if (in_ready !== 1'b0 || hdr_valid !== 1'b1 ||
          {hdr_core, hdr_ev, hdr_time, hdr_last} !== {16'h00A5, 8'h42, 32'h11112222, 1'b0}) begin
        failed++; $display("FAIL hdr_stall%0d: got rdy=%b v=%b core=%h ev=%h time=%h last=%b required rdy=0 v=1 00a5 42 11112222 0",
                           i, in_ready, hdr_valid, hdr_core, hdr_ev, hdr_time, hdr_last);
      end
      @(posedge clk); #1;
    end
    tests_run++;
    if (n_acc != acc0) begin
      failed++; $display("FAIL hdr_stall_consumed: got %0d flits required 0", n_acc - acc0);
    end
    hdr_ready = 1'b1;
    send_flit(tx_q.pop_front(), ok);
    send_flit(tx_q.pop_front(), ok2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++;
      if (in_ready !== 1'b0 || word_valid !== 1'b1 || {word_data, word_last} !== {32'hDEADBEEF, 1'b1}) begin
        failed++; $display("FAIL word_stall%0d: got rdy=%b v=%b data=%h last=%b required 0 1 deadbeef 1",
                           i, in_ready, word_valid, word_data, word_last);
      end
      @(posedge clk); #1;
    end
    word_ready = 1'b1;
    drain(2, ok);
    tests_run++;
    if (!ok || obs_q.size() != 2 || obs_q[0] !== exp_q[0] || obs_q[1] !== exp_q[1]) begin
      failed++; $display("FAIL stall_records: got %0d records required 2 matching model", obs_q.size());
    end
    rdy_rand = 1'b1;
  endtask

  task automatic test_err_evid();
    bit ok, ok2;
    start_test();
    push_head(4'h7); push_flit(2'b00, 16'h0001); push_flit(2'b10, 16'h0002);
    gen_snapshot_ok(2);
    send_all(ok); drain(exp_q.size(), ok2);
    tests_run++;
    if (obs_err - err0 != 1) begin
      failed++; $display("FAIL errevid_pulses: got %0d required 1", obs_err - err0);
    end
    tests_run++;
    if (!ok || !ok2 || obs_q.size() != exp_q.size()) begin
      failed++; $display("FAIL errevid_count: got %0d records required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      tests_run++;
      if (obs_q[i] !== exp_q[i]) begin
        failed++; $display("FAIL errevid_rec%0d: got %h required %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    bit ok, ok2;
    int kind;
    start_test();
    for (int p = 0; p < 40; p++) begin
      kind = $urandom_range(0, 5);
      case (kind)
        0, 1: gen_snapshot_ok($urandom_range(0, 3));
        2: gen_foreign($urandom_range(0, 3));
        3: push_flit(2'b11, 16'($urandom));
        4: push_flit($urandom_range(0, 1) ? 2'b00 : 2'b10, 16'($urandom));
        default: begin
          push_head(4'h7);
          for (int j = 0; j < $urandom_range(0, 2); j++) push_flit(2'b00, 16'($urandom));
          case ($urandom_range(0, 2))
            0: push_flit(2'b10, 16'($urandom));
            1: push_flit(2'b11, 16'($urandom));
            default: ;
          endcase
        end
      endcase
    end
    push_flit(2'b11, 16'h0000);
    send_all(ok); drain(exp_q.size(), ok2);
    tests_run++;
    if (!ok || !ok2 || obs_q.size() != exp_q.size()) begin
      failed++; $display("FAIL random_count: got %0d records required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      tests_run++;
      if (obs_q[i] !== exp_q[i]) begin
        failed++; $display("FAIL random_rec%0d: got %h required %h", i, obs_q[i], exp_q[i]);
      end
    end
    tests_run++;
    if (obs_err - err0 != exp_err) begin
      failed++; $display("FAIL random_err: got %0d pulses required %0d", obs_err - err0, exp_err);
    end
    tests_run++;
    if (drop_count !== 16'(m_drops)) begin
      failed++; $display("FAIL random_drop: got %0d required %0d", drop_count, m_drops);
    end
  endtask

  task automatic test_reset_mid();
    bit ok, ok2;
    start_test();
    push_head(4'h7);
    for (int i = 0; i < 5; i++) push_flit(2'b00, 16'($urandom));
    send_all(ok); drain(1, ok2);
    tests_run++;
    if (!ok || !ok2 || obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
      failed++; $display("FAIL rstmid_hdr: got %0d records required 1 matching model", obs_q.size());
    end
    #2 rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    tests_run++;
    if ({hdr_valid, word_valid, err, hdr_last, word_last, in_ready, drop_count, word_data, hdr_time} !== '0) begin
      failed++; $display("FAIL rstmid_outputs: got v=%b wv=%b err=%b rdy=%b drop=%h data=%h time=%h required all 0",
                         hdr_valid, word_valid, err, in_ready, drop_count, word_data, hdr_time);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    start_test();
    gen_snapshot_ok(2);
    send_all(ok); drain(exp_q.size(), ok2);
    tests_run++;
    if (!ok || !ok2 || obs_q.size() != exp_q.size()) begin
      failed++; $display("FAIL rstmid_count: got %0d records required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      tests_run++;
      if (obs_q[i] !== exp_q[i]) begin
        failed++; $display("FAIL rstmid_rec%0d: got %h required %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_drop_saturate();
    bit ok, ok2;
    int acc0;
    do_reset();
    start_test();
    for (int i = 0; i < 3; i++) gen_foreign(3);
    send_all(ok); drain(0, ok2);
    tests_run++;
    if (drop_count !== 16'd3 || obs_q.size() != 0 || obs_err != err0) begin
      failed++; $display("FAIL drop_small: got count=%0d records=%0d err=%0d required 3 0 0",
                         drop_count, obs_q.size(), obs_err - err0);
    end
    acc0 = n_acc;
    flit = {2'b11, 16'h0000}; in_valid = 1'b1;
    repeat (65535) @(posedge clk);
    #1 in_valid = 1'b0;
    for (int i = 0; i < 65535; i++) model_flit({2'b11, 16'h0000});
    tests_run++;
    if (n_acc - acc0 != 65535) begin
      failed++; $display("FAIL drop_accepts: got %0d flits required 65535", n_acc - acc0);
    end
    gen_foreign(3);
    send_all(ok); drain(0, ok2);
    tests_run++;
    if (drop_count !== 16'hFFFF || drop_count !== 16'(m_drops)) begin
      failed++; $display("FAIL drop_saturate: got %h required ffff (model %0d)", drop_count, m_drops);
    end
    tests_run++;
    if (obs_q.size() != 0 || obs_err != err0) begin
      failed++; $display("FAIL drop_outputs: got records=%0d err=%0d required 0 0", obs_q.size(), obs_err - err0);
    end
  endtask

  initial begin
    test_reset();
    rdy_rand = 1'b1;
    test_basic();
    test_hdr_only();
    test_hdr_stall();
    test_err_evid();
    test_random();
    test_reset_mid();
    test_drop_saturate();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
